// File: rtl/matrix_frame_arbiter_if.sv
// matrix_frame_arbiter_if: stream bundle between the requesters, the arbiter
// and the matrix engine.
//   s_tdata/s_tvalid/s_tlast : per-source input streams (source n at n*DATA_WIDTH)
//   s_tready                 : per-source ready back to the requesters
//   m_tdata/m_tvalid/m_tlast : forwarded stream to the engine
//   m_tready                 : engine ready
//   m_tid                    : index of the source owning the current frame
// Modports: slave = arbiter view, master = requester/engine (bench) view.
interface matrix_frame_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_SRC-1:0]            s_tvalid;
  logic [NUM_SRC-1:0]            s_tlast;
  logic [NUM_SRC-1:0]            s_tready;
  logic [DATA_WIDTH-1:0]         m_tdata;
  logic                          m_tvalid;
  logic                          m_tlast;
  logic                          m_tready;
  logic [1:0]                    m_tid;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );
endinterface

// File: rtl/matrix_frame_arbiter.sv
// matrix_frame_arbiter: frame-level round-robin arbiter feeding one matrix
// engine. Grants one source for exactly one SIZE*SIZE frame, forwards it
// combinationally, then spends one IDLE cycle re-arbitrating.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : stream bundle (slave modport), see matrix_frame_arbiter_if
//   len_err   : one-cycle pulse after a frame whose tlast disagreed with length
//   frame_cnt : completed frame count, wraps
module matrix_frame_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  matrix_frame_arbiter_if.slave        bus,
  output logic                         len_err,
  output logic [15:0]                  frame_cnt
);

  localparam int BEATS = SIZE * SIZE;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [1:0]       LAST_SRC  = 2'(NUM_SRC - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state, state_nxt;

  logic [1:0]            grant;
  logic [1:0]            rr_ptr;
  logic [1:0]            pick;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  any_req;
  logic                  busy;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  beat_full;
  logic                  accept;
  logic                  frame_end;

  // Granted-source mux; compare-based so grant never indexes past NUM_SRC.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant == 2'(i)) begin
        sel_valid = bus.s_tvalid[i];
        sel_last  = bus.s_tlast[i];
        sel_data  = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    pick  = rr_ptr;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = {30'b0, rr_ptr} + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
        if (!found && (idx == j) && bus.s_tvalid[j]) begin
          found = 1'b1;
          pick  = 2'(j);
        end
      end
    end
  end

  assign any_req   = |bus.s_tvalid;
  assign busy      = (state == BUSY);
  assign beat_full = (beat_cnt == LAST_BEAT);

  always_comb begin
    bus.s_tready = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (busy && (grant == 2'(i))) bus.s_tready[i] = bus.m_tready;
    end
  end

  assign bus.m_tvalid = busy & sel_valid;
  assign bus.m_tlast  = busy & (sel_last | beat_full);
  assign bus.m_tdata  = busy ? sel_data : '0;
  assign bus.m_tid    = grant;

  assign accept    = bus.m_tvalid & bus.m_tready;
  assign frame_end = accept & bus.m_tlast;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)   state_nxt = BUSY;
      BUSY:    if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      len_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      len_err <= 1'b0;
      if ((state == IDLE) && any_req) begin
        grant    <= pick;
        beat_cnt <= '0;
      end
      if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (frame_end) begin
          rr_ptr    <= (grant == LAST_SRC) ? 2'd0 : grant + 2'd1;
          frame_cnt <= frame_cnt + 16'd1;
          // Short frame (early tlast) or long frame (cut at full length).
          len_err   <= sel_last ^ beat_full;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_frame_arbiter.sv
module tb_matrix_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        len_err;
  logic [15:0] frame_cnt;

  matrix_frame_arbiter_if #(.NUM_SRC(4), .DATA_WIDTH(32)) bus ();

  matrix_frame_arbiter #(.NUM_SRC(4), .SIZE(4), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .len_err   (len_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [31:0] data;
    logic        last;
  } sbeat_t;

  typedef struct {
    logic [1:0]  tid;
    logic [31:0] data;
    logic        last;
  } exp_t;

  sbeat_t srcq[$];   // pending beats of every source, in per-source order
  exp_t   sb[$];     // expected engine-side beats, in output order

  int errors = 0;
  int checks = 0;
  int idle_cnt, lenerr_cnt, beats_out;
  int hidx[4];
  bit toggle_mode = 0;
  bit rdy_phase   = 1;
  bit mask_chk    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkdata(input int src, input int tag, input int beat);
    if (tag == 0) return 32'(beat - 1);
    return {8'(src), 8'(tag), 16'(beat)};
  endfunction

  // Source side: beats b0..b1, tlast on beat last_at (0 = never).
  task automatic load(input int src, input int tag, input int b0, input int b1, input int last_at);
    sbeat_t s;
    for (int b = b0; b <= b1; b++) begin
      s.src  = src;
      s.data = mkdata(src, tag, b);
      s.last = (b == last_at);
      srcq.push_back(s);
    end
  endtask

  // Engine side expectation: beats b0..b1 from src, m_tlast on beat last_at.
  task automatic expect_beats(input int src, input int tag, input int b0, input int b1, input int last_at);
    exp_t e;
    for (int b = b0; b <= b1; b++) begin
      e.tid  = 2'(src);
      e.data = mkdata(src, tag, b);
      e.last = (b == last_at);
      sb.push_back(e);
    end
  endtask

  task automatic drive();
    logic [127:0] d;
    logic [3:0]   v, l;
    d = '0; v = '0; l = '0;
    for (int n = 0; n < 4; n++) begin
      hidx[n] = -1;
      for (int q = 0; q < srcq.size(); q++) begin
        if (hidx[n] < 0 && srcq[q].src == n) begin
          hidx[n]       = q;
          d[n*32 +: 32] = srcq[q].data;
          v[n]          = 1'b1;
          l[n]          = srcq[q].last;
        end
      end
    end
    bus.s_tdata  = d;
    bus.s_tvalid = v;
    bus.s_tlast  = l;
    if (toggle_mode) rdy_phase = ~rdy_phase;
    else             rdy_phase = 1'b1;
    bus.m_tready = rdy_phase;
  endtask

  // One clock cycle: drive at negedge, sample/compare, then consume at posedge.
  task automatic step();
    exp_t e;
    int   acc;
    drive();
    #1;
    if (!bus.m_tvalid) idle_cnt++;
    if (len_err)       lenerr_cnt++;
    if (mask_chk && sb.size() > 0)
      chk("sready_mask", 64'(bus.s_tready & ~(4'b0001 << sb[0].tid)), 64'd0);
    if (bus.m_tvalid && bus.m_tready) begin
      beats_out++;
      if (sb.size() == 0) begin
        chk("unexpected_beat", 64'(bus.m_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("beat", {29'b0, bus.m_tid, bus.m_tdata, bus.m_tlast},
                    {29'b0, e.tid, e.data, e.last});
      end
    end
    acc = -1;
    for (int n = 0; n < 4; n++)
      if (bus.s_tvalid[n] && bus.s_tready[n]) acc = hidx[n];
    @(posedge clk);
    if (acc >= 0) srcq.delete(acc);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (sb.size() > 0 && c < budget) begin
      step();
      c++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    srcq.delete();
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.s_tdata  = '0;
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.m_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    // reset state
    chk("rst_s_tready",  64'(bus.s_tready), 64'd0);
    chk("rst_m_tvalid",  64'(bus.m_tvalid), 64'd0);
    chk("rst_m_tlast",   64'(bus.m_tlast),  64'd0);
    chk("rst_m_tid",     64'(bus.m_tid),    64'd0);
    chk("rst_len_err",   64'(len_err),      64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt),    64'd0);
    rst = 1'b0;

    // 1: single frame 0x00..0x0F from source 0
    lenerr_cnt = 0;
    load(0, 0, 1, 16, 16);
    expect_beats(0, 0, 1, 16, 16);
    drain(100);
    step();
    chk("t1_frame_cnt", 64'(frame_cnt),  64'd1);
    chk("t1_len_err",   64'(lenerr_cnt), 64'd0);

    // 2: all four sources continuously valid, grants 0,1,2,3,0
    do_reset();
    idle_cnt = 0; lenerr_cnt = 0;
    load(0, 2, 1, 16, 16);
    load(0, 3, 1, 16, 16);
    load(1, 2, 1, 16, 16);
    load(2, 2, 1, 16, 16);
    load(3, 2, 1, 16, 16);
    expect_beats(0, 2, 1, 16, 16);
    expect_beats(1, 2, 1, 16, 16);
    expect_beats(2, 2, 1, 16, 16);
    expect_beats(3, 2, 1, 16, 16);
    expect_beats(0, 3, 1, 16, 16);
    drain(200);
    chk("t2_idle_cycles", 64'(idle_cnt), 64'd5);
    step();
    chk("t2_frame_cnt", 64'(frame_cnt),  64'd5);
    chk("t2_len_err",   64'(lenerr_cnt), 64'd0);

    // 3: source 2 short frame (tlast on beat 10), then search resumes at 3
    lenerr_cnt = 0;
    load(2, 4, 1, 10, 10);
    expect_beats(2, 4, 1, 10, 10);
    drain(100);
    step();
    chk("t3_len_err", 64'(lenerr_cnt), 64'd1);
    load(0, 5, 1, 16, 16);
    load(1, 5, 1, 16, 16);
    load(3, 5, 1, 16, 16);
    expect_beats(3, 5, 1, 16, 16);
    expect_beats(0, 5, 1, 16, 16);
    expect_beats(1, 5, 1, 16, 16);
    drain(200);
    step();
    chk("t3_frame_cnt", 64'(frame_cnt),  64'd9);
    chk("t3_len_err2",  64'(lenerr_cnt), 64'd1);

    // 4: source 1 sends 20 beats, tlast only on beat 20; cut at 16
    lenerr_cnt = 0;
    load(1, 6, 1, 20, 20);
    expect_beats(1, 6, 1, 16, 16);
    expect_beats(3, 6, 1, 16, 16);
    expect_beats(0, 6, 1, 16, 16);
    expect_beats(1, 6, 17, 20, 20);
    step(); step(); step();
    load(0, 6, 1, 16, 16);
    load(3, 6, 1, 16, 16);
    drain(200);
    step();
    chk("t4_len_err",   64'(lenerr_cnt), 64'd2);
    chk("t4_frame_cnt", 64'(frame_cnt),  64'd13);

    // 5: m_tready toggling, other source waiting
    beats_out = 0; lenerr_cnt = 0;
    toggle_mode = 1; mask_chk = 1;
    load(2, 7, 1, 16, 16);
    load(0, 7, 1, 16, 16);
    expect_beats(2, 7, 1, 16, 16);
    expect_beats(0, 7, 1, 16, 16);
    drain(300);
    toggle_mode = 0; mask_chk = 0;
    step();
    chk("t5_beats",     64'(beats_out),  64'd32);
    chk("t5_frame_cnt", 64'(frame_cnt),  64'd15);
    chk("t5_len_err",   64'(lenerr_cnt), 64'd0);

    // 6: asynchronous reset at beat 7 of a source-3 frame
    load(3, 8, 1, 16, 16);
    expect_beats(3, 8, 1, 6, 0);
    drain(100);
    drive();
    #1;
    chk("t6_pre_valid", 64'(bus.m_tvalid), 64'd1);
    chk("t6_pre_tid",   64'(bus.m_tid),    64'd3);
    rst = 1'b1;
    #1;
    chk("t6_s_tready",  64'(bus.s_tready), 64'd0);
    chk("t6_m_tvalid",  64'(bus.m_tvalid), 64'd0);
    chk("t6_m_tlast",   64'(bus.m_tlast),  64'd0);
    chk("t6_m_tid",     64'(bus.m_tid),    64'd0);
    chk("t6_frame_cnt", 64'(frame_cnt),    64'd0);
    srcq.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    lenerr_cnt = 0;
    load(3, 9, 1, 16, 16);
    load(1, 9, 1, 16, 16);
    expect_beats(1, 9, 1, 16, 16);
    expect_beats(3, 9, 1, 16, 16);
    drain(200);
    step();
    chk("t6_frame_cnt2", 64'(frame_cnt),  64'd2);
    chk("t6_len_err",    64'(lenerr_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_frame_arbiter.md
# matrix_frame_arbiter

Frame-level round-robin arbiter that shares one matrix engine (reverse or transpose) between several AXI-Stream requesters. Each requester delivers whole SIZE×SIZE matrices, one element per beat. The block grants the engine to one source for exactly one matrix frame, then rotates to the next source. It sits directly in front of the engine's `in_*` stream port and tags each forwarded beat with the source index.

## Interface
- `NUM_SRC`, default 4: number of requesters, legal range 2..4.
- `SIZE`, default 4: matrix dimension; a frame is SIZE*SIZE beats.
- `DATA_WIDTH`, default 32: element width in bits.
- `clk`  input  1  clock; all logic is on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `s_tdata`  input  NUM_SRC*DATA_WIDTH  source data; source n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
- `s_tvalid`  input  NUM_SRC  per-source valid.
- `s_tlast`  input  NUM_SRC  per-source end-of-frame marker.
- `s_tready`  output  NUM_SRC  per-source ready.
- `m_tdata`  output  DATA_WIDTH  data to the engine.
- `m_tvalid`  output  1  valid to the engine.
- `m_tlast`  output  1  last beat of the forwarded frame.
- `m_tready`  input  1  engine ready (the engine's `in_tready`).
- `m_tid`  output  2  index of the granted source.
- `len_err`  output  1  one-cycle pulse: a frame-length violation was detected.
- `frame_cnt`  output  16  count of completed frames; wraps.

## Operation
- Two states: IDLE and BUSY. Registers:
  - `grant` (2 bits)
  - `rr_ptr` (2 bits)
  - `beat_cnt`, sized to hold SIZE*SIZE-1
  - `len_err`
  - `frame_cnt`
- IDLE:
  - All `s_tready` = 0 and `m_tvalid` = 0.
  - If any `s_tvalid` is high, select the first n with `s_tvalid[n]`, searching from `rr_ptr` upward and wrapping modulo NUM_SRC.
  - Load `grant` = n, set `beat_cnt` = 0, go to BUSY.
- BUSY, a pass-through path with no data registering:
  - `m_tdata` = source `grant`'s data; `m_tvalid` = `s_tvalid[grant]`.
  - `s_tready[grant]` = `m_tready`; every other `s_tready` = 0.
  - `m_tid` = `grant`.
  - `m_tlast` = `s_tlast[grant]` OR (`beat_cnt` == SIZE*SIZE-1).
- A beat is accepted when `m_tvalid` && `m_tready`. Each accepted beat increments `beat_cnt`.
- Frame end is an accepted beat with `m_tlast` = 1. On the frame-end clock edge:
  - state returns to IDLE;
  - `rr_ptr` = (`grant` + 1) mod NUM_SRC;
  - `frame_cnt` increments;
  - `len_err` is set for one cycle if exactly one of the following holds (XOR):
    - `s_tlast[grant]` is high;
    - `beat_cnt` == SIZE*SIZE-1.
- A short frame is one where `s_tlast` arrives early. It is truncated at that beat; the engine sees `m_tlast`.
- A long frame is one where `s_tlast` is missing at beat SIZE*SIZE-1. It is cut at that beat with `m_tlast` forced high. The source's remaining beats form the start of its next frame.
- `m_tid` holds its last value while in IDLE.
- Sources that are not granted are never dropped; they wait with `s_tready` = 0.
- With NUM_SRC < 4, `rr_ptr` and `grant` never exceed NUM_SRC-1.

## Timing
- Reset values:
  - state = IDLE; `grant` = 0, `rr_ptr` = 0, `beat_cnt` = 0.
  - `s_tready` = 0, `m_tvalid` = 0, `m_tlast` = 0, `m_tid` = 0.
  - `len_err` = 0, `frame_cnt` = 0.
- Reset is asynchronous. Asserting `rst` mid-frame drops state to IDLE immediately and all outputs take their reset values. The partial frame is abandoned, with no `m_tlast`.
- Arbitration latency: a request seen in IDLE at edge k gives BUSY from edge k+1. The first beat can be accepted in the cycle after edge k+1.
- The IDLE cycle between frames is mandatory: exactly one bubble cycle per frame.
- Combinational paths:
  - data, valid and last: zero latency from source to engine;
  - `m_tready` to `s_tready`: zero latency.
- `len_err` asserts the cycle after the offending frame-end edge and lasts exactly 1 cycle.
- Dropping `s_tvalid[grant]` mid-frame stalls the frame. The grant is held indefinitely; there is no timeout.
- Back-pressure: `m_tready` = 0 holds `beat_cnt` and the grant. The data presented must stay stable per AXI-Stream; this block does not check it.

## Test plan
- Reset, then source 0 sends 16 beats with values 0x00..0x0F and `tlast` on beat 16, with `m_tready` = 1.
  - Required: `m_tid` = 0; 16 beats out in order; `m_tlast` only on 0x0F; `frame_cnt` = 1; `len_err` = 0.
- All four sources hold `s_tvalid` = 1 continuously with correct 16-beat frames.
  - Required: grants in order 0, 1, 2, 3, 0; exactly one idle cycle between frames; `frame_cnt` = 5 after 5 frames.
- Source 2 asserts `s_tlast` on beat 10.
  - Required: frame ends after 10 beats with `m_tlast` = 1; `len_err` pulses once; next grant starts search from 3.
- Source 1 sends 20 beats with no `tlast`.
  - Required: `m_tlast` forced on beat 16; `len_err` pulses; source 1's next frame starts with beat 17 after other pending sources are served.
- `m_tready` toggles 1-0-1 every cycle during a frame.
  - Required: exactly 16 accepted beats, in order, with no duplicates; non-granted `s_tready` stays 0 throughout.
- Assert `rst` at beat 7 of a frame from source 3.
  - Required: outputs go to reset values in the same cycle without waiting for a clock edge; after release, the first grant goes to the lowest requesting index from 0.
